// File: rtl/stereo_pkg.sv
// stereo_pkg: frame geometry and bus widths shared by the stereo output path.
package stereo_pkg;
  localparam int IMG_W    = 320;
  localparam int IMG_H    = 240;
  localparam int MAX_DISP = 80;
  localparam int BYTE_W   = 8;
  localparam int WORD_W   = 4 * BYTE_W;
endpackage

// File: rtl/pix_pos_counter.sv
// pix_pos_counter: column/row position within a frame, stepped once per accepted pixel.
module pix_pos_counter #(
  parameter int W  = 320,
  parameter int H  = 240,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_col,
  output logic          last_row
);
  assign last_col = col == CW'(W - 1);
  assign last_row = row == RW'(H - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      col <= last_col ? '0 : col + 1'b1;
      if (last_col) row <= last_row ? '0 : row + 1'b1;
    end
endmodule

// File: rtl/disparity_packer_320.sv
// disparity_packer_320: packs 7-bit disparity bytes from a FWFT FIFO into 32-bit words
// with row/frame markers, zeroing the left border where no disparity exists.
module disparity_packer_320 import stereo_pkg::*; #(
  parameter int IMG_W    = stereo_pkg::IMG_W,
  parameter int IMG_H    = stereo_pkg::IMG_H,
  parameter int MAX_DISP = stereo_pkg::MAX_DISP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_empty_n,
  output logic              in_deq,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              m_sof,
  output logic              frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [1:0]          lane;
  logic [3*BYTE_W-1:0] pack;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic                last_col, last_row, out_last_row, load;
  logic [BYTE_W-1:0]   px;
  // lane 3 completes a word, so it may only pop when the output register can take it
  assign in_deq = rst_n & ~clr & in_empty_n & ((lane != 2'd3) | ~m_valid | m_ready);
  assign load   = in_deq & (lane == 2'd3);
  assign px     = (col < CW'(MAX_DISP)) ? '0 : in_data & {1'b0, {(BYTE_W-1){1'b1}}};
  pix_pos_counter #(.W(IMG_W), .H(IMG_H)) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .adv      (in_deq),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_row (last_row)
  );
  // bytes shift in from the top so the lowest column ends up in bits [7:0]
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lane         <= '0;
      pack         <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_sof        <= 1'b0;
      out_last_row <= 1'b0;
      frame_done   <= 1'b0;
    end else if (clr) begin
      lane         <= '0;
      pack         <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_sof        <= 1'b0;
      out_last_row <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= m_valid & m_ready & m_last & out_last_row;
      if (in_deq) begin
        lane <= lane + 1'b1;
        pack <= {px, pack[3*BYTE_W-1:BYTE_W]};
      end
      if (load) begin
        m_data       <= {px, pack};
        m_valid      <= 1'b1;
        m_last       <= last_col;
        m_sof        <= (row == '0) && (col == CW'(3));
        out_last_row <= last_row;
      end else if (m_ready) m_valid <= 1'b0;
    end
endmodule

// File: doc/disparity_packer_320.md
DISPARITY_PACKER_320 -- requirements
Module: disparity_packer_320

Interface
REQ-001 SHALL have parameter IMG_W, default 320, meaning pixels per row; must be a multiple of 4.
REQ-002 SHALL have parameter IMG_H, default 240, meaning rows per frame.
REQ-003 SHALL have parameter MAX_DISP, default 80, meaning left-border columns with no valid disparity.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clr, input, 1, synchronous clear.
REQ-007 SHALL have port in_data, input, 8, disparity byte taken from the stereo output FIFO dout.
REQ-008 SHALL have port in_empty_n, input, 1, high when in_data is valid (first-word-fall-through).
REQ-009 SHALL have port in_deq, output, 1, pops one byte from the stereo output FIFO in the same cycle.
REQ-010 SHALL have port m_data, output, 32, four packed disparity bytes.
REQ-011 SHALL have port m_valid, output, 1, m_data/m_last/m_sof are valid.
REQ-012 SHALL have port m_ready, input, 1, the downstream accepts the word when m_valid & m_ready.
REQ-013 SHALL have port m_last, output, 1, the word holds column IMG_W-1 of a row.
REQ-014 SHALL have port m_sof, output, 1, the word holds row 0, column 0.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse when the last word of a frame is accepted.

Function
REQ-016 SHALL accept a byte exactly when in_deq & in_empty_n; in_deq SHALL never be high while in_empty_n is low.
REQ-017 SHALL use a 2-bit lane counter, a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1), each advancing only on an accepted byte.
REQ-018 SHALL store the accepted byte in bits [8*lane+7:8*lane], so the lowest column sits in bits [7:0].
REQ-019 SHALL force bit 7 of every byte to 0 (the disparity is 7 bits), and SHALL force the whole byte to 0 when col < MAX_DISP.
REQ-020 SHALL assert in_deq for lanes 0-2 whenever in_empty_n is high.
REQ-021 SHALL assert in_deq for lane 3 only if in_empty_n is high and either m_valid is low or m_ready is high in that cycle.
REQ-022 SHALL, on accepting lane 3, load the assembled word, m_last and m_sof into the output register and set m_valid in the next cycle; latency from the lane-3 byte to m_valid is 1 cycle.
REQ-023 SHALL, when a lane-3 load coincides with the current word being accepted, hold m_valid high with the new word, leaving no bubble.
REQ-024 SHALL hold m_data, m_last and m_sof stable while m_valid & !m_ready.
REQ-025 SHALL clear m_valid after the word is accepted if no new word is loaded.
REQ-026 SHALL wrap col from IMG_W-1 to 0 and increment row; SHALL wrap row from IMG_H-1 to 0.
REQ-027 SHALL set m_last for the word in which col = IMG_W-1, and m_sof for the word in which row = 0 and col = 0.
REQ-028 SHALL pulse frame_done for one cycle, in the cycle after acceptance of a word that has m_last set and row IMG_H-1.
REQ-029 SHALL sustain one byte per cycle while m_ready is held high.

Reset
REQ-030 SHALL, on rst_n low (asynchronous), clear lane, col, row, the pack register, m_data, m_valid, m_last, m_sof, frame_done and in_deq to 0.
REQ-031 SHALL, on clr high at a clock edge, apply the same clearing as REQ-030; this discards any partial word and any pending output word.
REQ-032 SHALL give clr priority over the accept and load of the same cycle.

Structure
REQ-033 SHALL place IMG_W, IMG_H, MAX_DISP and the byte/word widths in a shared package, stereo_pkg.
REQ-034 SHALL place the col/row counting in one sub-module, pix_pos_counter, which outputs col, row, last_col and last_row.

Verification
REQ-035 SHALL cover: after reset, feed bytes 0x85,0x01,0x02,0x03 at cols 80-83 with m_ready=1 -> m_data=0x03020105 one cycle after the 4th byte, m_valid=1, m_last=0.
REQ-036 SHALL cover: first row, all input bytes 0x7F -> the first 20 words equal 0x00000000, word 20 equals 0x7F7F7F7F, m_sof=1 on word 0 only.
REQ-037 SHALL cover: m_ready held 0 for 10 cycles with a full FIFO -> exactly 7 bytes are popped (3 lanes, 1 load, 3 lanes), m_data stays stable, no byte is lost after m_ready rises.
REQ-038 SHALL cover: a full 320x240 frame with random m_ready -> 19200 words, m_last on every 80th word, a single frame_done pulse after the 19200th acceptance, and row wrap so the next word carries m_sof=1.
REQ-039 SHALL cover: clr asserted after 2 bytes of a word -> lane/col/row return to 0, m_valid=0, and the next byte lands in bits [7:0] with m_sof=1.
REQ-040 SHALL cover: rst_n pulled low mid-row, asynchronously between clock edges -> all outputs are 0 immediately, before the next clock edge.
